// File: rtl/baccarat_round_ctrl.sv
// Baccarat round controller: sequences the card-load strobes, applies the third-card tableau,
// and holds the result lamps. start->load_pcard1 takes 1 cycle; start is ignored while busy.
module baccarat_round_ctrl #(
  parameter int CNT_W        = 8,
  parameter int HOLD_CYCLES  = 4,
  parameter int AUTO_RESTART = 0,
  parameter int TIE_LIGHTS   = 1
) (
  input  logic             slow_clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       pscore,
  input  logic [3:0]       dscore,
  input  logic [3:0]       pcard3,
  output logic             load_pcard1,
  output logic             load_pcard2,
  output logic             load_pcard3,
  output logic             load_dcard1,
  output logic             load_dcard2,
  output logic             load_dcard3,
  output logic             player_win_light,
  output logic             dealer_win_light,
  output logic             busy,
  output logic             round_done,
  output logic [CNT_W-1:0] player_wins,
  output logic [CNT_W-1:0] dealer_wins,
  output logic [CNT_W-1:0] ties,
  output logic [CNT_W-1:0] rounds
);

  typedef enum logic [3:0] {
    S_IDLE, S_DEAL_P1, S_DEAL_D1, S_DEAL_P2, S_DEAL_D2, S_EVAL2,
    S_DEAL_P3, S_EVAL_D3, S_DEAL_D3, S_COMPARE, S_HOLD
  } state_t;

  typedef enum logic [1:0] {RES_NONE, RES_P, RES_D, RES_T} result_t;

  localparam int              HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t            state_q, state_d;
  result_t           result_q, result_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [CNT_W-1:0]  pwins_q, pwins_d, dwins_q, dwins_d, ties_q, ties_d, rounds_q, rounds_d;
  logic [3:0]        v3;
  logic              natural, dealer_draw;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  // Face cards and tens count zero; code 0 means no third card was dealt.
  always_comb begin
    v3      = (pcard3 != 4'd0 && pcard3 <= 4'd9) ? pcard3 : 4'd0;
    natural = (pscore >= 4'd8) || (dscore >= 4'd8);
    case (dscore)
      4'd0, 4'd1, 4'd2: dealer_draw = 1'b1;
      4'd3:             dealer_draw = (v3 != 4'd8);
      4'd4:             dealer_draw = (v3 >= 4'd2) && (v3 <= 4'd7);
      4'd5:             dealer_draw = (v3 >= 4'd4) && (v3 <= 4'd7);
      4'd6:             dealer_draw = (v3 >= 4'd6) && (v3 <= 4'd7);
      default:          dealer_draw = 1'b0;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    result_d         = result_q;
    hold_d           = hold_q;
    pwins_d          = pwins_q;
    dwins_d          = dwins_q;
    ties_d           = ties_q;
    rounds_d         = rounds_q;
    load_pcard1      = 1'b0;
    load_pcard2      = 1'b0;
    load_pcard3      = 1'b0;
    load_dcard1      = 1'b0;
    load_dcard2      = 1'b0;
    load_dcard3      = 1'b0;
    player_win_light = 1'b0;
    dealer_win_light = 1'b0;
    round_done       = 1'b0;
    busy             = (state_q != S_IDLE);

    case (state_q)
      S_IDLE:    if (start) state_d = S_DEAL_P1;
      S_DEAL_P1: begin load_pcard1 = 1'b1; state_d = S_DEAL_D1; end
      S_DEAL_D1: begin load_dcard1 = 1'b1; state_d = S_DEAL_P2; end
      S_DEAL_P2: begin load_pcard2 = 1'b1; state_d = S_DEAL_D2; end
      S_DEAL_D2: begin load_dcard2 = 1'b1; state_d = S_EVAL2;   end
      S_EVAL2: begin
        if (natural)                state_d = S_COMPARE;
        else if (pscore <= 4'd5)    state_d = S_DEAL_P3;
        else if (dscore <= 4'd5)    state_d = S_DEAL_D3;
        else                        state_d = S_COMPARE;
      end
      S_DEAL_P3: begin load_pcard3 = 1'b1; state_d = S_EVAL_D3; end
      S_EVAL_D3: state_d = dealer_draw ? S_DEAL_D3 : S_COMPARE;
      // One spare cycle lets the datapath fold the dealer's third card into dscore.
      S_DEAL_D3: begin load_dcard3 = 1'b1; state_d = S_COMPARE; end
      S_COMPARE: begin
        if (pscore > dscore)      result_d = RES_P;
        else if (dscore > pscore) result_d = RES_D;
        else                      result_d = RES_T;
        hold_d  = '0;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        player_win_light = (result_q == RES_P) || (result_q == RES_T && TIE_LIGHTS != 0);
        dealer_win_light = (result_q == RES_D) || (result_q == RES_T && TIE_LIGHTS != 0);
        if (hold_q == '0) begin
          round_done = 1'b1;
          rounds_d   = sat_inc(rounds_q);
          if (result_q == RES_P) pwins_d = sat_inc(pwins_q);
          if (result_q == RES_D) dwins_d = sat_inc(dwins_q);
          if (result_q == RES_T) ties_d  = sat_inc(ties_q);
        end
        if (hold_q == HOLD_LAST) state_d = (AUTO_RESTART != 0) ? S_DEAL_P1 : S_IDLE;
        else                     hold_d  = hold_q + HW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge slow_clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      result_q <= RES_NONE;
      hold_q   <= '0;
      pwins_q  <= '0;
      dwins_q  <= '0;
      ties_q   <= '0;
      rounds_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      hold_q   <= hold_d;
      pwins_q  <= pwins_d;
      dwins_q  <= dwins_d;
      ties_q   <= ties_d;
      rounds_q <= rounds_d;
    end
  end

  assign player_wins = pwins_q;
  assign dealer_wins = dwins_q;
  assign ties        = ties_q;
  assign rounds      = rounds_q;

endmodule

// File: tb/tb_baccarat_round_ctrl.sv
// Bench for baccarat_round_ctrl: a card-holding datapath model feeds the scores, a card-level
// rules model predicts draws and winners; a second instance covers saturation/auto-restart/no tie lamps.
module tb_baccarat_round_ctrl;
  localparam int HOLD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start;
  logic [3:0] pscore, dscore, pcard3;
  logic       lp1, lp2, lp3, ld1, ld2, ld3, plt, dlt, busy, rdone;
  logic [7:0] pw, dw, tw, rw;

  baccarat_round_ctrl #(.CNT_W(8), .HOLD_CYCLES(HOLD), .AUTO_RESTART(0), .TIE_LIGHTS(1)) dut (
    .slow_clock(clk), .reset(reset), .start(start),
    .pscore(pscore), .dscore(dscore), .pcard3(pcard3),
    .load_pcard1(lp1), .load_pcard2(lp2), .load_pcard3(lp3),
    .load_dcard1(ld1), .load_dcard2(ld2), .load_dcard3(ld3),
    .player_win_light(plt), .dealer_win_light(dlt), .busy(busy), .round_done(rdone),
    .player_wins(pw), .dealer_wins(dw), .ties(tw), .rounds(rw));

  logic       reset2, start2, busy2, rd2, plt2, dlt2;
  logic [3:0] ps2, ds2, pc3_2;
  logic       l2p1, l2p2, l2p3, l2d1, l2d2, l2d3;
  logic [1:0] pw2, dw2, tw2, rw2;

  baccarat_round_ctrl #(.CNT_W(2), .HOLD_CYCLES(2), .AUTO_RESTART(1), .TIE_LIGHTS(0)) dut2 (
    .slow_clock(clk), .reset(reset2), .start(start2),
    .pscore(ps2), .dscore(ds2), .pcard3(pc3_2),
    .load_pcard1(l2p1), .load_pcard2(l2p2), .load_pcard3(l2p3),
    .load_dcard1(l2d1), .load_dcard2(l2d2), .load_dcard3(l2d3),
    .player_win_light(plt2), .dealer_win_light(dlt2), .busy(busy2), .round_done(rd2),
    .player_wins(pw2), .dealer_wins(dw2), .ties(tw2), .rounds(rw2));

  function automatic int cv(input int c);
    return (c >= 1 && c <= 9) ? c : 0;
  endfunction

  // Card datapath: the shoe for this round sits in deck_*, hands fill on the load strobes.
  logic [3:0] deck_p[3], deck_d[3], hp[3], hd[3];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin hp[i] <= 4'd0; hd[i] <= 4'd0; end
    end else begin
      if (lp1) begin hp[0] <= deck_p[0]; hp[2] <= 4'd0; hd[2] <= 4'd0; end
      if (lp2) hp[1] <= deck_p[1];
      if (lp3) hp[2] <= deck_p[2];
      if (ld1) hd[0] <= deck_d[0];
      if (ld2) hd[1] <= deck_d[1];
      if (ld3) hd[2] <= deck_d[2];
    end
  end
  always_comb begin
    pscore = 4'((cv(int'(hp[0])) + cv(int'(hp[1])) + cv(int'(hp[2]))) % 10);
    dscore = 4'((cv(int'(hd[0])) + cv(int'(hd[1])) + cv(int'(hd[2]))) % 10);
    pcard3 = hp[2];
  end

  int checks = 0, errors = 0;
  int m_pw = 0, m_dw = 0, m_tw = 0, m_rw = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Card-level baccarat rules: res 1=player, 2=dealer, 3=tie.
  task automatic ref_round(input int p1, p2, p3, d1, d2, d3, output int pd, dd, res);
    int ps, ds, v;
    ps = (cv(p1) + cv(p2)) % 10;
    ds = (cv(d1) + cv(d2)) % 10;
    pd = 0; dd = 0;
    if (ps < 8 && ds < 8) begin
      if (ps <= 5) begin
        pd = 1;
        v  = cv(p3);
        ps = (ps + v) % 10;
        if (ds <= 2)      dd = 1;
        else if (ds == 3) dd = (v != 8);
        else if (ds == 4) dd = (v >= 2 && v <= 7);
        else if (ds == 5) dd = (v >= 4 && v <= 7);
        else if (ds == 6) dd = (v >= 6 && v <= 7);
      end else begin
        dd = (ds <= 5);
      end
      if (dd != 0) ds = (ds + cv(d3)) % 10;
    end
    res = (ps > ds) ? 1 : (ds > ps) ? 2 : 3;
  endtask

  task automatic play(input int p1, p2, p3, d1, d2, d3, input int epd, edd, eres,
                      input bit poke, input string nm);
    int cyc, done_cyc, n_p3, n_d3, lit_p, lit_d, stray;
    deck_p[0] = 4'(p1); deck_p[1] = 4'(p2); deck_p[2] = 4'(p3);
    deck_d[0] = 4'(d1); deck_d[1] = 4'(d2); deck_d[2] = 4'(d3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({nm, "_lat"}, int'(lp1), 1);
    cyc = 1; done_cyc = 0; n_p3 = 0; n_d3 = 0; lit_p = 0; lit_d = 0; stray = 0;
    while (busy && cyc < 60) begin
      if (lp3) n_p3++;
      if (ld3) n_d3++;
      if (rdone && done_cyc == 0) done_cyc = cyc;
      if (plt) begin lit_p++; if (done_cyc == 0 || cyc >= done_cyc + HOLD) stray++; end
      if (dlt) begin lit_d++; if (done_cyc == 0 || cyc >= done_cyc + HOLD) stray++; end
      start = (poke && cyc == 3);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({nm, "_pcard3"}, n_p3, epd);
    chk({nm, "_dcard3"}, n_d3, edd);
    chk({nm, "_done_cyc"}, done_cyc, 7 + 2 * epd + edd);
    chk({nm, "_end_cyc"}, cyc, 7 + 2 * epd + edd + HOLD);
    chk({nm, "_plamp"}, lit_p, (eres == 1 || eres == 3) ? HOLD : 0);
    chk({nm, "_dlamp"}, lit_d, (eres == 2 || eres == 3) ? HOLD : 0);
    chk({nm, "_stray"}, stray + int'(plt) + int'(dlt), 0);
    m_rw = (m_rw < 255) ? m_rw + 1 : m_rw;
    if (eres == 1) m_pw = (m_pw < 255) ? m_pw + 1 : m_pw;
    if (eres == 2) m_dw = (m_dw < 255) ? m_dw + 1 : m_dw;
    if (eres == 3) m_tw = (m_tw < 255) ? m_tw + 1 : m_tw;
    chk({nm, "_rounds"}, int'(rw), m_rw);
    chk({nm, "_pwins"}, int'(pw), m_pw);
    chk({nm, "_dwins"}, int'(dw), m_dw);
    chk({nm, "_ties"}, int'(tw), m_tw);
    if (poke) begin
      repeat (3) @(negedge clk);
      chk({nm, "_idle"}, int'(busy), 0);
    end
  endtask

  typedef struct {
    int p1, p2, p3, d1, d2, d3;
    int pd, dd, res;
  } vec_t;

  initial begin
    vec_t tbl[10];
    int pd, dd, res, cyc, nd, last, bad_gap, plit, dlit, tlit;
    bit found;

    tbl[0] = '{4, 5, 1, 1, 2, 1, 0, 0, 1};   // player natural 9 vs 3
    tbl[1] = '{1, 1, 5, 2, 2, 10, 1, 1, 1};  // both draw, final 7 vs 4
    tbl[2] = '{10, 10, 8, 1, 2, 5, 1, 0, 1}; // dealer 3 stands on an 8
    tbl[3] = '{3, 3, 2, 2, 3, 4, 0, 1, 2};   // player stands 6, dealer 5 draws
    tbl[4] = '{3, 4, 1, 5, 2, 1, 0, 0, 3};   // tie 7-7
    tbl[5] = '{11, 1, 6, 3, 3, 2, 1, 1, 2};  // dealer 6 draws on a 6
    tbl[6] = '{2, 2, 12, 1, 2, 1, 1, 1, 3};  // face third card counts 0
    tbl[7] = '{1, 1, 5, 3, 3, 9, 1, 0, 1};   // dealer 6 stands on a 5
    tbl[8] = '{1, 2, 3, 2, 3, 9, 1, 0, 1};   // dealer 5 stands on a 3
    tbl[9] = '{2, 3, 9, 4, 4, 9, 0, 0, 2};   // dealer natural 8

    reset = 1'b1; start = 1'b0;
    reset2 = 1'b1; start2 = 1'b0; ps2 = 4'd0; ds2 = 4'd0; pc3_2 = 4'd0;
    for (int i = 0; i < 3; i++) begin deck_p[i] = 4'd0; deck_d[i] = 4'd0; end
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_loads", int'({lp1, lp2, lp3, ld1, ld2, ld3}), 0);
    chk("rst_lamps", int'({plt, dlt, rdone}), 0);
    chk("rst_cnt", int'(pw) + int'(dw) + int'(tw) + int'(rw), 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++)
      play(tbl[i].p1, tbl[i].p2, tbl[i].p3, tbl[i].d1, tbl[i].d2, tbl[i].d3,
           tbl[i].pd, tbl[i].dd, tbl[i].res, 1'b0, $sformatf("vec%0d", i));

    play(4, 5, 1, 1, 2, 1, 0, 0, 1, 1'b1, "busy_start");

    // Abort in DEAL_D3: next cycle idle with counters cleared.
    deck_p[0] = 4'd1; deck_p[1] = 4'd1; deck_p[2] = 4'd5;
    deck_d[0] = 4'd2; deck_d[1] = 4'd2; deck_d[2] = 4'd10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (ld3) found = 1'b1;
      else @(negedge clk);
    end
    chk("abort_reach_d3", int'(found), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_loads", int'({lp1, lp2, lp3, ld1, ld2, ld3}), 0);
    chk("abort_cnt", int'(pw) + int'(dw) + int'(tw) + int'(rw), 0);
    reset = 1'b0;
    m_pw = 0; m_dw = 0; m_tw = 0; m_rw = 0;
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      int c[6];
      for (int k = 0; k < 6; k++) c[k] = int'($urandom_range(1, 13));
      ref_round(c[0], c[1], c[2], c[3], c[4], c[5], pd, dd, res);
      play(c[0], c[1], c[2], c[3], c[4], c[5], pd, dd, res, 1'b0, $sformatf("rnd%0d", i));
    end

    // Second instance: 3 ties then 5 player naturals, back-to-back with start low.
    reset2 = 1'b0;
    ps2 = 4'd7; ds2 = 4'd7;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    cyc = 0; nd = 0; last = -1; bad_gap = 0; plit = 0; dlit = 0; tlit = 0;
    while (nd < 8 && cyc < 200) begin
      if (rd2) begin
        if (last >= 0 && cyc - last != 8) bad_gap++;
        last = cyc;
        nd++;
        if (nd == 3) begin ps2 = 4'd9; ds2 = 4'd3; end
      end
      if (nd <= 3 && (plt2 || dlt2)) tlit++;
      if (nd >= 4 && plt2) plit++;
      if (dlt2) dlit++;
      @(negedge clk);
      cyc++;
    end
    if (plt2) plit++;
    if (dlt2) dlit++;
    chk("auto_rounds_seen", nd, 8);
    chk("auto_gap", bad_gap, 0);
    chk("tie_no_lamps", tlit, 0);
    chk("auto_plamp", plit, 10);
    chk("auto_dlamp", dlit, 0);
    chk("sat_ties", int'(tw2), 3);
    chk("sat_pwins", int'(pw2), 3);
    chk("sat_dwins", int'(dw2), 0);
    chk("sat_rounds", int'(rw2), 3);
    chk("auto_busy", int'(busy2), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
